// File: rtl/hough_vote_arbiter.sv
// rtl/hough_vote_arbiter.sv - round-robin vote arbiter with RMW increment and clear sequencer for a Hough accumulator
// Optional macro HOUGH_VOTE_SATURATE_EN: saturate bin increments instead of wrapping.
module hough_vote_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int R_WIDTH     = 13,
   parameter int ANGLE_WIDTH = 8,
   parameter int R_BIAS      = 1024,
   parameter int R_BITS      = 11,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*R_WIDTH-1:0]     req_r,
   input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           clear_start,
   output logic                           clear_busy,
   output logic [6+R_BITS-1:0]            acc_raddr,
   input  logic [COUNT_WIDTH-1:0]         acc_rdata,
   output logic [6+R_BITS-1:0]            acc_waddr,
   output logic [COUNT_WIDTH-1:0]         acc_wdata,
   output logic                           acc_we,
   output logic                           busy,
   output logic [15:0]                    dropped_count
);

   localparam int AW = 6 + R_BITS;
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR_WAIT, S_CLEAR} state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          rr_q, rr_d;
   logic                   b_valid_q, b_valid_d;
   logic [AW-1:0]          b_addr_q, b_addr_d;
   logic                   fwd_we_q, fwd_we_d;
   logic [AW-1:0]          fwd_addr_q, fwd_addr_d;
   logic [COUNT_WIDTH-1:0] fwd_data_q, fwd_data_d;
   logic [AW-1:0]          clr_addr_q, clr_addr_d;
   logic [15:0]            drop_q, drop_d;

   logic [NUM_REQ-1:0]     grant;
   logic [PW-1:0]          gidx;
   logic                   found;
   int                     idx;
   logic                   xfer;
   logic [R_WIDTH-1:0]     sel_r;
   logic [5:0]             sel_ang;
   logic signed [R_WIDTH:0] rb;
   logic                   in_range;
   logic [AW-1:0]          vote_addr;
   logic [COUNT_WIDTH-1:0] old_cnt;
   logic [COUNT_WIDTH-1:0] inc_cnt;

   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      if (!reset && state_q == S_IDLE) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
               found      = 1'b1;
               gidx       = PW'(idx);
               grant[idx] = 1'b1;
            end
         end
      end
   end

   assign req_ready = grant;
   assign xfer      = |grant;
   assign sel_r     = req_r[int'(gidx)*R_WIDTH +: R_WIDTH];
   assign sel_ang   = req_angle[int'(gidx)*ANGLE_WIDTH + 2 +: 6];
   assign rb        = $signed({sel_r[R_WIDTH-1], sel_r}) + $signed((R_WIDTH+1)'(R_BIAS));
   assign in_range  = ~rb[R_WIDTH] & ~|(rb[R_WIDTH-1:0] >> R_BITS);
   assign vote_addr = {sel_ang, rb[R_BITS-1:0]};

   // Read-first RAM: a write issued last cycle to the same bin is not yet visible in acc_rdata.
   assign old_cnt = (fwd_we_q && fwd_addr_q == b_addr_q) ? fwd_data_q : acc_rdata;

`ifdef HOUGH_VOTE_SATURATE_EN
   assign inc_cnt = (old_cnt == '1) ? old_cnt : old_cnt + 1'b1;
`else
   assign inc_cnt = old_cnt + 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      b_valid_d  = 1'b0;
      b_addr_d   = b_addr_q;
      clr_addr_d = clr_addr_q;
      drop_d     = drop_q;
      acc_we     = 1'b0;
      acc_waddr  = '0;
      acc_wdata  = '0;
      acc_raddr  = '0;

      if (b_valid_q) begin
         acc_we    = 1'b1;
         acc_waddr = b_addr_q;
         acc_wdata = inc_cnt;
      end

      if (xfer) begin
         rr_d = (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
         if (in_range) begin
            acc_raddr = vote_addr;
            b_valid_d = 1'b1;
            b_addr_d  = vote_addr;
         end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (clear_start) state_d = S_CLEAR_WAIT;
         end
         S_CLEAR_WAIT: begin
            // Grants are off here, so whatever sits in stage B retires this cycle.
            state_d    = S_CLEAR;
            clr_addr_d = '0;
         end
         S_CLEAR: begin
            acc_we     = 1'b1;
            acc_waddr  = clr_addr_q;
            acc_wdata  = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      fwd_we_d   = acc_we;
      fwd_addr_d = acc_waddr;
      fwd_data_d = acc_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rr_q       <= '0;
         b_valid_q  <= 1'b0;
         b_addr_q   <= '0;
         fwd_we_q   <= 1'b0;
         fwd_addr_q <= '0;
         fwd_data_q <= '0;
         clr_addr_q <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         b_valid_q  <= b_valid_d;
         b_addr_q   <= b_addr_d;
         fwd_we_q   <= fwd_we_d;
         fwd_addr_q <= fwd_addr_d;
         fwd_data_q <= fwd_data_d;
         clr_addr_q <= clr_addr_d;
         drop_q     <= drop_d;
      end
   end

   assign clear_busy    = (state_q != S_IDLE);
   assign busy          = clear_busy | b_valid_q;
   assign dropped_count = drop_q;

endmodule

// File: tb/tb_hough_vote_arbiter.sv
// tb/tb_hough_vote_arbiter.sv - directed self-checking bench for hough_vote_arbiter
// A second, narrow instance (R_BITS=4) keeps the full-RAM clear sweep short.
module tb_hough_vote_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // main instance, default parameters
   logic [1:0]  m_valid;
   logic [25:0] m_r;
   logic [15:0] m_angle;
   logic [1:0]  m_ready;
   logic        m_clear, m_cbusy, m_we, m_busy;
   logic [16:0] m_raddr, m_waddr;
   logic [7:0]  m_rdata, m_wdata;
   logic [15:0] m_drop;

   // small instance for the clear sweep
   logic [1:0]  s_valid;
   logic [25:0] s_r;
   logic [15:0] s_angle;
   logic [1:0]  s_ready;
   logic        s_clear, s_cbusy, s_we, s_busy;
   logic [9:0]  s_raddr, s_waddr;
   logic [7:0]  s_rdata, s_wdata;
   logic [15:0] s_drop;

   hough_vote_arbiter dut_m (
      .clk(clk), .reset(reset), .req_valid(m_valid), .req_r(m_r), .req_angle(m_angle),
      .req_ready(m_ready), .clear_start(m_clear), .clear_busy(m_cbusy), .acc_raddr(m_raddr),
      .acc_rdata(m_rdata), .acc_waddr(m_waddr), .acc_wdata(m_wdata), .acc_we(m_we),
      .busy(m_busy), .dropped_count(m_drop)
   );

   hough_vote_arbiter #(.R_BIAS(8), .R_BITS(4)) dut_s (
      .clk(clk), .reset(reset), .req_valid(s_valid), .req_r(s_r), .req_angle(s_angle),
      .req_ready(s_ready), .clear_start(s_clear), .clear_busy(s_cbusy), .acc_raddr(s_raddr),
      .acc_rdata(s_rdata), .acc_waddr(s_waddr), .acc_wdata(s_wdata), .acc_we(s_we),
      .busy(s_busy), .dropped_count(s_drop)
   );

   // read-first RAM models with a bench-side preload port
   logic [7:0]  m_mem [0:131071];
   logic [7:0]  s_mem [0:1023];
   logic        pre_we, pre_sel;
   logic [16:0] pre_addr;
   logic [7:0]  pre_data;

   always @(posedge clk) begin
      m_rdata <= m_mem[m_raddr];
      s_rdata <= s_mem[s_raddr];
      if (m_we) m_mem[m_waddr] <= m_wdata;
      if (s_we) s_mem[s_waddr] <= s_wdata;
      if (pre_we && !pre_sel) m_mem[pre_addr] <= pre_data;
      if (pre_we && pre_sel)  s_mem[pre_addr[9:0]] <= pre_data;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic ram_put(input logic sel, input logic [16:0] addr, input logic [7:0] data);
      pre_sel  = sel;
      pre_addr = addr;
      pre_data = data;
      pre_we   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [7:0] sat_exp;
   int         bad;

   initial begin
      m_valid = '0; m_r = '0; m_angle = '0; m_clear = 1'b0;
      s_valid = '0; s_r = '0; s_angle = '0; s_clear = 1'b0;
      pre_we = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;
      bad = 0;

      do_reset();
      check_eq("rst_ready", 32'(m_ready), 32'h0);
      check_eq("rst_we", 32'(m_we), 32'h0);
      check_eq("rst_busy", 32'(m_busy), 32'h0);
      check_eq("rst_cbusy", 32'(m_cbusy), 32'h0);
      check_eq("rst_drop", 32'(m_drop), 32'h0);
      check_eq("rst_waddr", 32'(m_waddr), 32'h0);

      // single vote r=5 angle=8 -> bin 0x1405
      ram_put(1'b0, 17'h1405, 8'd0);
      m_valid = 2'b01; m_r[12:0] = 13'd5; m_angle[7:0] = 8'd8;
      #1;
      check_eq("v1_ready", 32'(m_ready), 32'h1);
      check_eq("v1_raddr", 32'(m_raddr), 32'h1405);
      step();
      m_valid = 2'b00;
      #1;
      check_eq("v1_we", 32'(m_we), 32'h1);
      check_eq("v1_waddr", 32'(m_waddr), 32'h1405);
      check_eq("v1_wdata", 32'(m_wdata), 32'h1);
      check_eq("v1_busy", 32'(m_busy), 32'h1);
      step();

      // three back-to-back votes r=-3 angle=0 -> bin 0x3FD, starting at 7
      ram_put(1'b0, 17'h03FD, 8'd7);
      m_valid = 2'b01; m_r[12:0] = 13'h1FFD; m_angle[7:0] = 8'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) m_valid = 2'b00;
         check_eq("fwd_waddr", 32'(m_waddr), 32'h3FD);
         check_eq("fwd_wdata", 32'(m_wdata), 32'(8 + i));
      end
      step();

      // both requesters continuously valid from rr=0 -> grants alternate
      do_reset();
      m_valid = 2'b11;
      m_r = {13'd10, 13'd5}; m_angle = {8'd12, 8'd8};
      for (int i = 0; i < 6; i++) begin
         #1;
         check_eq("rr_grant", 32'(m_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
         step();
      end
      m_valid = 2'b00;
      step();

      // out-of-range votes: rb=2124, then rb=-1
      m_valid = 2'b01; m_r[12:0] = 13'd1100; m_angle[7:0] = 8'd4;
      step();
      check_eq("drop1_we", 32'(m_we), 32'h0);
      check_eq("drop1_cnt", 32'(m_drop), 32'd1);
      m_r[12:0] = 13'h1BFF;
      step();
      m_valid = 2'b00;
      check_eq("drop2_we", 32'(m_we), 32'h0);
      check_eq("drop2_cnt", 32'(m_drop), 32'd2);
      step();

      // full bin: r=0 angle=16 -> bin 0x2400 holding 255
`ifdef HOUGH_VOTE_SATURATE_EN
      sat_exp = 8'd255;
`else
      sat_exp = 8'd0;
`endif
      ram_put(1'b0, 17'h2400, 8'd255);
      m_valid = 2'b01; m_r[12:0] = 13'd0; m_angle[7:0] = 8'd16;
      step();
      m_valid = 2'b00;
      check_eq("full_we", 32'(m_we), 32'h1);
      check_eq("full_wdata", 32'(m_wdata), 32'(sat_exp));
      step();

      // clear_start together with a vote on the small instance (r=0 -> bin 8)
      ram_put(1'b1, 17'd8, 8'd3);
      s_valid = 2'b01; s_r[12:0] = 13'd0; s_angle[7:0] = 8'd0; s_clear = 1'b1;
      #1;
      check_eq("clr_vote_ready", 32'(s_ready), 32'h1);
      step();
      s_clear = 1'b0;
      check_eq("clr_vote_we", 32'(s_we), 32'h1);
      check_eq("clr_vote_waddr", 32'(s_waddr), 32'd8);
      check_eq("clr_vote_wdata", 32'(s_wdata), 32'd4);
      check_eq("clr_wait_cbusy", 32'(s_cbusy), 32'h1);
      check_eq("clr_wait_ready", 32'(s_ready), 32'h0);
      for (int k = 0; k < 1024; k++) begin
         step();
         if (k == 0) s_clear = 1'b1;
         if (k == 1) s_clear = 1'b0;
         if (s_we !== 1'b1 || s_wdata !== 8'd0 || s_waddr !== 10'(k) ||
             s_ready !== 2'b00 || s_cbusy !== 1'b1)
            bad++;
      end
      check_eq("clr_sweep_bad_cycles", 32'(bad), 32'd0);
      step();
      check_eq("clr_done_cbusy", 32'(s_cbusy), 32'h0);
      check_eq("clr_done_we", 32'(s_we), 32'h0);
      check_eq("clr_done_ready", 32'(s_ready), 32'h1);
      s_valid = 2'b00;
      step();
      check_eq("clr_bin8", 32'(s_mem[8]), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hough_vote_arbiter.md
Name: hough_vote_arbiter

Overview:
- Shares one Hough accumulator RAM between NUM_REQ vote producers (per-pixel r/angle calculators).
- Round-robin arbitrates their (r, angle) vote streams and turns each accepted vote into a pipelined read-modify-write increment of one accumulator bin.
- Also sequences the full-RAM clear that runs before each frame.
- Sits between the calculators and the simple-dual-port accumulator BRAM.

Parameters:
- NUM_REQ, 2: number of vote requesters.
- R_WIDTH, 13: signed r width per vote.
- ANGLE_WIDTH, 8: angle width per vote. Angles are multiples of 4, range 0..176.
- R_BIAS, 1024: added to r to form an unsigned bin index.
- R_BITS, 11: r-bin address bits. Bins are 0..2^R_BITS-1.
- COUNT_WIDTH, 8: width of an accumulator bin.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  vote valid, one bit per requester.
- req_r  in  NUM_REQ*R_WIDTH  signed r. Requester i uses slice [i*R_WIDTH +: R_WIDTH].
- req_angle  in  NUM_REQ*ANGLE_WIDTH  angle, sliced the same way.
- req_ready  out  NUM_REQ  one-hot grant.
- clear_start  in  1  one-cycle pulse that requests an accumulator clear.
- clear_busy  out  1  high while a clear is pending or running.
- acc_raddr  out  6+R_BITS  accumulator read address.
- acc_rdata  in  COUNT_WIDTH  read data, valid 1 cycle after acc_raddr.
- acc_waddr  out  6+R_BITS  accumulator write address.
- acc_wdata  out  COUNT_WIDTH  write data.
- acc_we  out  1  write enable.
- busy  out  1  high while any vote is in flight or a clear is pending or running.
- dropped_count  out  16  number of votes rejected as out of range. Saturates at 65535.

Behaviour:
- Address formation:
  - rb = r + R_BIAS, computed signed at R_WIDTH+1 bits.
  - addr = {angle[7:2], rb[R_BITS-1:0]}.
  - If rb < 0 or rb >= 2^R_BITS, the vote is still accepted but dropped: no RAM access, and dropped_count increments.
- Handshake:
  - req_ready is combinational from req_valid, the round-robin pointer and mode.
  - At most one bit is high. It is never high during reset, CLEAR_WAIT or CLEAR.
  - A transfer happens on the cycle req_valid[i] & req_ready[i].
  - A requester holds its r and angle stable until the transfer.
- Arbitration:
  - Search starts at pointer rr.
  - The first valid requester at or after rr (wrapping) is granted.
  - After a transfer, rr = granted+1 mod NUM_REQ.
  - With no transfer, rr holds.
- Pipeline:
  - Accepts 1 vote per cycle, sustained.
  - Stage A (accept cycle): acc_raddr = addr. A valid flag and addr are registered.
  - Stage B (next cycle): old = acc_rdata, unless the forwarding case below applies.
  - Write in stage B: acc_we=1, acc_waddr = addr, acc_wdata = old+1.
  - Vote-to-write latency: 1 cycle.
- Forwarding:
  - The RAM is read-first, so back-to-back votes to the same address would otherwise lose a count.
  - If stage B's addr equals the address written in the previous cycle (acc_we was 1), old = the registered previous acc_wdata instead of acc_rdata.
  - Interleaved same-address votes (A, B, A) need no forwarding, since 2 cycles separate them.
- Controller states:
  - IDLE: arbitrating; the pipeline may be active.
  - CLEAR_WAIT: grants stop; wait until stage B is empty (at most 1 cycle).
  - CLEAR:
    - acc_we=1, acc_wdata=0, acc_waddr sweeps 0..2^(6+R_BITS)-1, one address per cycle.
    - After the last address, go to IDLE.
    - Duration: 2^(6+R_BITS) cycles.
- Clear sequencing:
  - clear_start in IDLE moves to CLEAR_WAIT.
  - clear_start while in CLEAR_WAIT or CLEAR is ignored.
  - If clear_start and a transfer occur on the same cycle, the vote is accepted and completes before the clear.
  - clear_busy is high from the cycle after clear_start until the last clear write.
- Reset:
  - rr=0, state IDLE, pipeline emptied, acc_we=0, acc_raddr/acc_waddr/acc_wdata=0, dropped_count=0, clear_busy=0, busy=0.
  - A reset mid-clear or mid-vote abandons the operation.
  - RAM contents are not guaranteed after such a reset; software must issue clear_start.

Optional Feature:
- Macro: HOUGH_VOTE_SATURATE_EN.
- Defined: acc_wdata = old+1 saturating at 2^COUNT_WIDTH-1. A full bin still gets a write, with the same value.
- Undefined: acc_wdata = old+1 mod 2^COUNT_WIDTH, so a full bin wraps to 0.

Test Plan:
- Reset, then req0 votes r=5, angle=8 with RAM bin 0 -> acc_raddr=0x1405. Next cycle acc_we=1, acc_waddr=0x1405, acc_wdata=1.
- req0 sends 3 consecutive votes r=-3, angle=0 (addr 0x3FD), RAM initially 7 -> writes 8, 9, 10 on consecutive cycles (forwarding exercised).
- req0 and req1 both continuously valid for 6 cycles -> grants alternate 0,1,0,1,0,1; neither requester starved.
- Vote r=1100, angle=4 (rb=2124) -> no acc_we, dropped_count goes 0->1. Vote r=-1025 -> dropped_count=2.
- clear_start while a vote is in flight -> the vote's write completes, then acc_we=1 with wdata=0 for 131072 consecutive cycles at addresses 0..0x1FFFF. req_ready=0 throughout. clear_busy falls after the last write.
- Bin at 255, one vote -> acc_wdata=255 with HOUGH_VOTE_SATURATE_EN, 0 without.
